// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the configurable UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_mode_t;

  localparam int MIN_DATA_BITS = 5;

  function automatic logic [3:0] clamp_data_bits(input logic [3:0] req,
                                                 input logic [3:0] max_bits);
    if (req < 4'(MIN_DATA_BITS)) return 4'(MIN_DATA_BITS);
    if (req > max_bits) return max_bits;
    return req;
  endfunction

  function automatic parity_mode_t parity_mode(input logic en, input logic odd);
    if (!en) return PAR_NONE;
    return odd ? PAR_ODD : PAR_EVEN;
  endfunction

  // Clocks per frame: start + data + optional parity + one or two stops.
  function automatic int unsigned frame_clocks(input int unsigned div,
                                               input int unsigned nbits,
                                               input logic parity_en,
                                               input logic stop2);
    return (div + 1) * (2 + nbits + 32'(parity_en) + 32'(stop2));
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read data and an occupancy count.
module uart_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_WIDTH-1:0]         din,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with runtime baud divisor, 5..DATA_WIDTH data bits, optional
// parity, one or two stop bits, and an input FIFO decoupling the producer.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic [DIV_WIDTH-1:0]          cfg_div,
  input  logic [3:0]                    cfg_data_bits,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_parity_odd,
  input  logic                          cfg_stop2
);

  localparam logic [3:0] MAX_BITS = 4'(DATA_WIDTH);

  tx_state_t             state, state_next;
  logic [DIV_WIDTH-1:0]  baud_cnt, baud_cnt_next;
  logic [DIV_WIDTH-1:0]  div_q, div_q_next;
  logic [3:0]            bit_cnt, bit_cnt_next;
  logic [3:0]            nbits_q, nbits_q_next;
  logic [DATA_WIDTH-1:0] shift_q, shift_next;
  parity_mode_t          par_q, par_next;
  logic                  stop2_q, stop2_next;
  logic                  stop_cnt, stop_cnt_next;
  logic                  par_acc, par_acc_next;
  logic                  tx_next;
  logic                  bit_end;
  logic                  load;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [DATA_WIDTH-1:0] fifo_dout;

  uart_sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (din_valid),
    .pop   (fifo_pop),
    .din   (din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign din_ready = !fifo_full;
  assign busy      = (state != ST_IDLE);
  assign bit_end   = (baud_cnt == div_q);

  always_comb begin
    state_next    = state;
    baud_cnt_next = bit_end ? '0 : baud_cnt + 1'b1;
    div_q_next    = div_q;
    bit_cnt_next  = bit_cnt;
    nbits_q_next  = nbits_q;
    shift_next    = shift_q;
    par_next      = par_q;
    stop2_next    = stop2_q;
    stop_cnt_next = stop_cnt;
    par_acc_next  = par_acc;
    load          = 1'b0;
    fifo_pop      = 1'b0;
    tx_next       = 1'b1;

    case (state)
      ST_IDLE: begin
        baud_cnt_next = '0;
        if (!fifo_empty) load = 1'b1;
      end
      ST_START: begin
        if (bit_end) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_next   = shift_q >> 1;
          par_acc_next = par_acc ^ shift_q[0];
          if (bit_cnt == nbits_q - 4'd1) begin
            bit_cnt_next = '0;
            state_next   = (par_q == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_cnt == stop2_q) begin
            stop_cnt_next = 1'b0;
            if (!fifo_empty) load = 1'b1;
            else state_next = ST_IDLE;
          end else begin
            stop_cnt_next = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Frame start: pop the next word and freeze the configuration for this frame.
    if (load) begin
      fifo_pop      = 1'b1;
      state_next    = ST_START;
      baud_cnt_next = '0;
      bit_cnt_next  = '0;
      stop_cnt_next = 1'b0;
      par_acc_next  = 1'b0;
      shift_next    = fifo_dout;
      div_q_next    = cfg_div;
      nbits_q_next  = clamp_data_bits(cfg_data_bits, MAX_BITS);
      par_next      = parity_mode(cfg_parity_en, cfg_parity_odd);
      stop2_next    = cfg_stop2;
    end

    // tx is registered, so it is computed from the state about to be entered.
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_next[0];
      ST_PARITY: tx_next = par_acc_next ^ (par_q == PAR_ODD);
      default:   tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      div_q    <= '0;
      bit_cnt  <= '0;
      nbits_q  <= 4'(MIN_DATA_BITS);
      shift_q  <= '0;
      par_q    <= PAR_NONE;
      stop2_q  <= 1'b0;
      stop_cnt <= 1'b0;
      par_acc  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_cnt_next;
      div_q    <= div_q_next;
      bit_cnt  <= bit_cnt_next;
      nbits_q  <= nbits_q_next;
      shift_q  <= shift_next;
      par_q    <= par_next;
      stop2_q  <= stop2_next;
      stop_cnt <= stop_cnt_next;
      par_acc  <= par_acc_next;
      tx       <= tx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: fixed frame vectors, directed corner
// sequences and randomized bursts checked against a frame-level model.
module tb_uart_tx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int DIVW  = 16;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [DW-1:0]   din = '0;
  logic            din_valid = 1'b0;
  logic            din_ready;
  logic            tx;
  logic            busy;
  logic [4:0]      fifo_level;
  logic [DIVW-1:0] cfg_div = '0;
  logic [3:0]      cfg_data_bits = 4'd8;
  logic            cfg_parity_en = 1'b0;
  logic            cfg_parity_odd = 1'b0;
  logic            cfg_stop2 = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic          exp_tx[$];
  int            frame_len[$];
  logic [DW-1:0] push_words[$];

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic [3:0]  bits;
    logic        pen;
    logic        podd;
    logic        stop2;
    logic [15:0] exp_bits;
    int          exp_clocks;
  } vec_t;

  vec_t vecs[5];

  uart_tx_fifo #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .DIV_WIDTH (DIVW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .din           (din),
    .din_valid     (din_valid),
    .din_ready     (din_ready),
    .tx            (tx),
    .busy          (busy),
    .fifo_level    (fifo_level),
    .cfg_div       (cfg_div),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity_en (cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd),
    .cfg_stop2     (cfg_stop2)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic set_cfg(input int div, input int bits, input logic pen,
                         input logic podd, input logic stop2);
    cfg_div        = 16'(div);
    cfg_data_bits  = 4'(bits);
    cfg_parity_en  = pen;
    cfg_parity_odd = podd;
    cfg_stop2      = stop2;
  endtask

  // Reference frame: bit list from the line rules, each bit stretched to div+1 clocks.
  function automatic void model_frame(input logic [DW-1:0] word, input int div,
                                      input int req_bits, input logic pen,
                                      input logic podd, input logic stop2);
    int   n;
    logic par;
    logic bits[$];
    n   = (req_bits < 5) ? 5 : ((req_bits > DW) ? DW : req_bits);
    par = podd;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(word[i]);
      par ^= word[i];
    end
    if (pen) bits.push_back(par);
    bits.push_back(1'b1);
    if (stop2) bits.push_back(1'b1);
    foreach (bits[b])
      for (int c = 0; c <= div; c++) exp_tx.push_back(bits[b]);
    frame_len.push_back(bits.size() * (div + 1));
  endfunction

  function automatic void table_frame(input vec_t v);
    for (int c = 0; c < v.exp_clocks; c++)
      exp_tx.push_back(v.exp_bits[c / (int'(v.div) + 1)]);
    frame_len.push_back(v.exp_clocks);
  endfunction

  // Called at the negedge where the first word is driven; frames start one edge after acceptance.
  task automatic monitor_frames(input string tag);
    int idx;
    int bad;
    int first_bad;
    idx = 0;
    @(posedge clock);
    @(posedge clock);
    foreach (frame_len[f]) begin
      bad = 0;
      first_bad = -1;
      for (int c = 0; c < frame_len[f]; c++) begin
        @(negedge clock);
        if (tx !== exp_tx[idx] || busy !== 1'b1) begin
          bad++;
          if (first_bad < 0) first_bad = c;
        end
        idx++;
      end
      check_output($sformatf("%s frame%0d bad cycles (first at %0d)", tag, f, first_bad), bad, 0);
    end
    @(negedge clock);
    check_output({tag, " idle {busy,tx}"}, int'({busy, tx}), 1);
    check_output({tag, " idle fifo_level"}, int'(fifo_level), 0);
    exp_tx.delete();
    frame_len.delete();
  endtask

  task automatic drive_burst(input string tag);
    foreach (push_words[i]) begin
      din       = push_words[i];
      din_valid = 1'b1;
      check_output($sformatf("%s din_ready before push %0d", tag, i), int'(din_ready), 1);
      @(negedge clock);
    end
    din_valid = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] w;

    vecs[0] = '{8'hA5, 16'd3, 4'd8,  1'b0, 1'b0, 1'b0, 16'h034A, 40};
    vecs[1] = '{8'h41, 16'd1, 4'd7,  1'b1, 1'b0, 1'b1, 16'h0682, 22};
    vecs[2] = '{8'h41, 16'd1, 4'd7,  1'b1, 1'b1, 1'b1, 16'h0782, 22};
    vecs[3] = '{8'h3C, 16'd0, 4'd12, 1'b0, 1'b0, 1'b0, 16'h0278, 10};
    vecs[4] = '{8'hF3, 16'd2, 4'd3,  1'b1, 1'b1, 1'b0, 16'h00A6, 24};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_output("reset tx", int'(tx), 1);
    check_output("reset busy", int'(busy), 0);
    check_output("reset fifo_level", int'(fifo_level), 0);
    check_output("reset din_ready", int'(din_ready), 1);

    foreach (vecs[v]) begin
      set_cfg(int'(vecs[v].div), int'(vecs[v].bits), vecs[v].pen, vecs[v].podd, vecs[v].stop2);
      table_frame(vecs[v]);
      fork
        begin
          din       = vecs[v].data;
          din_valid = 1'b1;
          @(negedge clock);
          din_valid = 1'b0;
          check_output($sformatf("vec%0d tx high at accept", v), int'(tx), 1);
          check_output($sformatf("vec%0d fifo_level at accept", v), int'(fifo_level), 1);
        end
        monitor_frames($sformatf("vec%0d", v));
      join
      @(negedge clock);
    end

    // FIFO fill: 17 words taken (one into the shifter), the rest refused.
    set_cfg(100, 8, 1'b0, 1'b0, 1'b0);
    push_words.delete();
    for (int i = 0; i < 17; i++) begin
      w = DW'($urandom);
      push_words.push_back(w);
      model_frame(w, 100, 8, 1'b0, 1'b0, 1'b0);
    end
    fork
      begin
        for (int c = 0; c < 20; c++) begin
          din       = (c < 17) ? push_words[c] : 8'hEE;
          din_valid = 1'b1;
          check_output($sformatf("full din_ready cycle %0d", c), int'(din_ready), (c < 17) ? 1 : 0);
          @(negedge clock);
        end
        din_valid = 1'b0;
        check_output("full fifo_level", int'(fifo_level), 16);
        check_output("full din_ready", int'(din_ready), 0);
      end
      monitor_frames("fifo_full");
    join
    @(negedge clock);

    // Config change mid-frame only affects the following frame.
    set_cfg(3, 8, 1'b0, 1'b0, 1'b0);
    model_frame(8'h5A, 3, 8, 1'b0, 1'b0, 1'b0);
    model_frame(8'hC3, 7, 8, 1'b0, 1'b0, 1'b1);
    fork
      begin
        din       = 8'h5A;
        din_valid = 1'b1;
        @(negedge clock);
        din_valid = 1'b0;
        repeat (9) @(negedge clock);
        set_cfg(7, 8, 1'b0, 1'b0, 1'b1);
        din       = 8'hC3;
        din_valid = 1'b1;
        @(negedge clock);
        din_valid = 1'b0;
      end
      monitor_frames("cfg_change");
    join
    @(negedge clock);

    // Reset in the middle of a data bit with three words still queued.
    set_cfg(3, 8, 1'b0, 1'b0, 1'b0);
    push_words.delete();
    for (int i = 0; i < 4; i++) push_words.push_back(8'h00);
    drive_burst("pre_reset");
    check_output("pre_reset fifo_level", int'(fifo_level), 3);
    repeat (8) @(negedge clock);
    check_output("pre_reset tx in data", int'(tx), 0);
    check_output("pre_reset busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_output("post_reset tx", int'(tx), 1);
    check_output("post_reset busy", int'(busy), 0);
    check_output("post_reset fifo_level", int'(fifo_level), 0);
    check_output("post_reset din_ready", int'(din_ready), 1);
    push_words.delete();
    push_words.push_back(8'h96);
    model_frame(8'h96, 3, 8, 1'b0, 1'b0, 1'b0);
    fork
      drive_burst("post_reset");
      monitor_frames("post_reset");
    join
    @(negedge clock);

    // One-clock bits, clamped width, push coinciding with the first pop.
    set_cfg(0, 12, 1'b0, 1'b0, 1'b0);
    model_frame(8'h81, 0, 12, 1'b0, 1'b0, 1'b0);
    model_frame(8'h7E, 0, 12, 1'b0, 1'b0, 1'b0);
    fork
      begin
        din       = 8'h81;
        din_valid = 1'b1;
        @(negedge clock);
        check_output("pushpop level after first push", int'(fifo_level), 1);
        din = 8'h7E;
        @(negedge clock);
        din_valid = 1'b0;
        check_output("pushpop level after push+pop", int'(fifo_level), 1);
      end
      monitor_frames("pushpop");
    join
    @(negedge clock);

    for (int r = 0; r < 8; r++) begin
      int   div;
      int   bits;
      int   n;
      logic pen;
      logic podd;
      logic stop2;
      div   = int'($urandom_range(0, 3));
      bits  = int'($urandom_range(3, 11));
      pen   = 1'($urandom);
      podd  = 1'($urandom);
      stop2 = 1'($urandom);
      n     = int'($urandom_range(1, 4));
      set_cfg(div, bits, pen, podd, stop2);
      push_words.delete();
      for (int i = 0; i < n; i++) begin
        w = DW'($urandom);
        push_words.push_back(w);
        model_frame(w, div, bits, pen, podd, stop2);
      end
      fork
        drive_burst($sformatf("rand%0d", r));
        monitor_frames($sformatf("rand%0d", r));
      join
      repeat ($urandom_range(1, 3)) @(negedge clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
